enigma_keystroke_ctrl: RTL
==========================

// Module: enigma_keystroke_ctrl
// PURPOSE
//  Per-keystroke sequencer for the Enigma datapath (plugboard, 4 rotors, reflector).
//  Accepts one ASCII char per valid/ready handshake and validates it.
//  For a letter: normalises it to index 0..25, pulses the rotor step once, waits for the
//  combinational rotor/reflector path to settle, then captures the result and returns it
//  as ASCII. Replaces the free-running error checks with per-character, handshaked flags.
// PARAMETERS
//  SETTLE_CYCLES  2   cycles between step pulse and capture (>=1)
//  CNT_W          16  width of char_count
// PORTS
//  clk         in   1      system clock
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      in_char valid
//  in_ready    out  1      ctrl can accept a char (high only in IDLE)
//  in_char     in   8      ASCII keystroke
//  step        out  1      one-cycle rotor advance pulse (to rotor_1 chain)
//  core_in     out  5      letter index 0..25 driven into plugboard
//  core_out    in   5      letter index 0..25 returned from reflector path
//  out_valid   out  1      result valid; held until out_ready
//  out_ready   in   1      downstream accepts result
//  out_char    out  8      ASCII result
//  err_invalid out  1      qualifies out_valid: input was not A-Z/a-z
//  err_self    out  1      qualifies out_valid: letter enciphered to itself (fault)
//  busy        out  1      high in any state except IDLE
//  char_count  out  CNT_W  number of valid letters enciphered since reset
// BEHAVIOUR
//  Reset (synchronous, active-high; cycle-accurate outputs):
//   state=IDLE; in_ready=1; step=0; out_valid=0; err_*=0; out_char=0; core_in=0;
//   char_count=0. Reset mid-operation aborts the char: no step, no out_valid, no count.
//  FSM: IDLE -> STEP -> SETTLE -> CAPTURE -> OUT -> IDLE; invalid char: IDLE -> OUT.
//   IDLE: in_ready=1. On in_valid: latch in_char, case bit (lower = 97..122).
//    Letter: core_in = char-65 (upper) / char-97 (lower) -> STEP.
//    Non-letter (<65, 91..96, >122): out_char=8'h3F '?', err_invalid=1 -> OUT.
//   STEP: step=1 for exactly this cycle; core_in held -> SETTLE, counter cleared.
//   SETTLE: count SETTLE_CYCLES cycles, core_in held -> CAPTURE.
//   CAPTURE: sample core_out. out_char = core_out + (lower ? 97 : 65).
//    err_self = (core_out == core_in). char_count += 1 (wraps 2^CNT_W-1 -> 0) -> OUT.
//   OUT: out_valid=1; out_char/err_* stable until out_valid&&out_ready -> IDLE.
//    err_* cleared on leaving OUT.
//  Latency: handshake at cycle 0 -> step at 1 -> capture at 2+SETTLE_CYCLES
//   -> out_valid at 3+SETTLE_CYCLES. Invalid: out_valid at cycle 1.
//  Throughput: one char in flight; in_ready low from accept until output handshake.
//  Backpressure: out_ready low holds OUT indefinitely; no step or input accepted.
//  core_out >= 26 in CAPTURE: treated as fault: err_self=1, out_char='?', still counted.
//  err_invalid and err_self never both set. step never asserted outside STEP.
// STRUCTURE
//  enigma_pkg: state enum (IDLE, STEP, SETTLE, CAPTURE, OUT);
//   ASCII_UP_A=65, ASCII_UP_Z=90, ASCII_LO_A=97, ASCII_LO_Z=122, ASCII_QMARK=63, N_LETTERS=26.
//  Sub-module ascii_letter_codec (combinational): char -> {is_letter, is_lower, idx[4:0]}
//   and {idx, is_lower} -> char; used for encode in IDLE and decode in CAPTURE.
//  Rotor/plugboard/reflector instances stay outside; connect via step/core_in/core_out.
// TESTING
//  1 Reset then 'A' (8'h41), SETTLE=2, stub core_out=5 -> step pulse at cycle 1 only,
//    out_valid at cycle 5, out_char='F' (8'h46), err_*=0, char_count=1.
//  2 'z' (8'h7A), stub returns 3 -> core_in=25, out_char='d' (8'h64), case preserved.
//  3 '5' (8'h35) and '[' (8'h5B) -> out_valid at cycle 1, out_char=8'h3F, err_invalid=1,
//    no step, char_count unchanged.
//  4 'C', stub core_out=2 -> err_self=1, out_char='C'; next char clears err_self.
//  5 out_ready low 10 cycles in OUT -> out_char stable, in_ready=0, step=0; release -> IDLE.
//  6 rst asserted in SETTLE -> next cycle IDLE, out_valid=0, no count; CNT_W=4, 16 letters
//    -> char_count wraps to 0.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and ASCII constants for the Enigma keystroke sequencer.
package enigma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      SETTLE,
      CAPTURE,
      OUT
   } state_t;

   localparam logic [7:0] ASCII_UP_A  = 8'd65;
   localparam logic [7:0] ASCII_UP_Z  = 8'd90;
   localparam logic [7:0] ASCII_LO_A  = 8'd97;
   localparam logic [7:0] ASCII_LO_Z  = 8'd122;
   localparam logic [7:0] ASCII_QMARK = 8'd63;
   localparam logic [4:0] N_LETTERS   = 5'd26;

endpackage

// File: rtl/ascii_letter_codec.sv
// Combinational ASCII <-> letter-index conversion; encode path from a raw char,
// decode path from a rotor index plus case bit (out-of-range index decodes to '?').
module ascii_letter_codec
   import enigma_pkg::*;
(
   input  logic [7:0] char_in,
   output logic       is_letter,
   output logic       is_lower,
   output logic [4:0] idx_out,
   input  logic [4:0] idx_in,
   input  logic       lower_in,
   output logic [7:0] char_out
);

   logic       is_upper;
   logic [7:0] idx_full;

   always_comb begin
      is_upper  = (char_in >= ASCII_UP_A) && (char_in <= ASCII_UP_Z);
      is_lower  = (char_in >= ASCII_LO_A) && (char_in <= ASCII_LO_Z);
      is_letter = is_upper || is_lower;
      idx_full  = char_in - (is_lower ? ASCII_LO_A : ASCII_UP_A);
      idx_out   = is_letter ? idx_full[4:0] : 5'd0;

      if (idx_in < N_LETTERS) begin
         char_out = {3'b000, idx_in} + (lower_in ? ASCII_LO_A : ASCII_UP_A);
      end else begin
         char_out = ASCII_QMARK;
      end
   end

endmodule

// File: rtl/enigma_keystroke_ctrl.sv
// Per-keystroke sequencer: validates a char, steps the rotors once, waits for the
// combinational cipher path to settle, captures the result and hands it downstream.
module enigma_keystroke_ctrl
   import enigma_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_char,
   output logic             step,
   output logic [4:0]       core_in,
   input  logic [4:0]       core_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_char,
   output logic             err_invalid,
   output logic             err_self,
   output logic             busy,
   output logic [CNT_W-1:0] char_count
);

   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

   state_t           state_reg, state_next;
   logic [4:0]       core_in_reg, core_in_next;
   logic             lower_reg, lower_next;
   logic [7:0]       out_char_reg, out_char_next;
   logic             err_invalid_reg, err_invalid_next;
   logic             err_self_reg, err_self_next;
   logic [SC_W-1:0]  settle_cnt_reg, settle_cnt_next;
   logic [CNT_W-1:0] char_count_reg, char_count_next;

   logic             enc_is_letter;
   logic             enc_is_lower;
   logic [4:0]       enc_idx;
   logic [7:0]       dec_char;

   ascii_letter_codec u_codec (
      .char_in   (in_char),
      .is_letter (enc_is_letter),
      .is_lower  (enc_is_lower),
      .idx_out   (enc_idx),
      .idx_in    (core_out),
      .lower_in  (lower_reg),
      .char_out  (dec_char)
   );

   always_comb begin
      state_next       = state_reg;
      core_in_next     = core_in_reg;
      lower_next       = lower_reg;
      out_char_next    = out_char_reg;
      err_invalid_next = err_invalid_reg;
      err_self_next    = err_self_reg;
      settle_cnt_next  = settle_cnt_reg;
      char_count_next  = char_count_reg;

      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (enc_is_letter) begin
                  core_in_next = enc_idx;
                  lower_next   = enc_is_lower;
                  state_next   = STEP;
               end else begin
                  out_char_next    = ASCII_QMARK;
                  err_invalid_next = 1'b1;
                  state_next       = OUT;
               end
            end
         end
         STEP: begin
            settle_cnt_next = '0;
            state_next      = SETTLE;
         end
         SETTLE: begin
            if (settle_cnt_reg == SETTLE_LAST) begin
               state_next = CAPTURE;
            end else begin
               settle_cnt_next = settle_cnt_reg + 1'b1;
            end
         end
         CAPTURE: begin
            // An index outside the alphabet is a wiring fault, reported like a self-map.
            out_char_next   = dec_char;
            err_self_next   = (core_out >= N_LETTERS) || (core_out == core_in_reg);
            char_count_next = char_count_reg + 1'b1;
            state_next      = OUT;
         end
         OUT: begin
            if (out_ready) begin
               err_invalid_next = 1'b0;
               err_self_next    = 1'b0;
               state_next       = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         core_in_reg     <= '0;
         lower_reg       <= 1'b0;
         out_char_reg    <= '0;
         err_invalid_reg <= 1'b0;
         err_self_reg    <= 1'b0;
         settle_cnt_reg  <= '0;
         char_count_reg  <= '0;
      end else begin
         state_reg       <= state_next;
         core_in_reg     <= core_in_next;
         lower_reg       <= lower_next;
         out_char_reg    <= out_char_next;
         err_invalid_reg <= err_invalid_next;
         err_self_reg    <= err_self_next;
         settle_cnt_reg  <= settle_cnt_next;
         char_count_reg  <= char_count_next;
      end
   end

   assign in_ready    = (state_reg == IDLE);
   assign busy        = (state_reg != IDLE);
   assign step        = (state_reg == STEP);
   assign out_valid   = (state_reg == OUT);
   assign core_in     = core_in_reg;
   assign out_char    = out_char_reg;
   assign err_invalid = err_invalid_reg;
   assign err_self    = err_self_reg;
   assign char_count  = char_count_reg;

endmodule
